grf_dumper: RTL
===============

# grf_dumper

Debug read-back engine for the general register file. On a start pulse it walks the GRF's asynchronous read port from index 0 to NREG-1, registers each value, and streams it out as an (index, data) beat over a valid/ready handshake. It accumulates a running checksum and pulses done after the last beat. It attaches to a spare GRF read port, or to A1 while the core is halted, and feeds a trace/UART/testbench sink.

## Interface
- NREG, 32, number of registers dumped (2..2^AW)
- AW, 5, register index width
- DW, 32, register data width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  begin a dump; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle after the last handshake
- rd_addr  out  AW  GRF read address
- rd_data  in  DW  GRF read data; combinational function of rd_addr, valid in the same cycle
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts the beat
- out_idx  out  AW  register index of the current beat
- out_data  out  DW  register value of the current beat
- out_last  out  1  current beat is index NREG-1
- checksum  out  DW  sum of accepted out_data, mod 2^DW; holds until the next start
- done  out  1  one-cycle pulse after the final handshake

## Operation
- State machine: IDLE, READ, SEND.
- IDLE:
  - rd_addr=0, out_valid=0.
  - start=1 → ptr<=0, checksum<=0, busy<=1, go to READ.
- READ:
  - rd_addr=ptr.
  - At the edge: out_data<=rd_data, out_idx<=ptr, out_last<=(ptr==NREG-1), out_valid<=1, go to SEND.
- SEND:
  - rd_addr=ptr. out_valid, out_idx, out_data and out_last are held stable while out_ready=0.
  - Handshake (out_valid & out_ready) at an edge: out_valid<=0, checksum<=checksum+out_data (truncated to DW).
  - After the handshake, if out_last=0: ptr<=ptr+1, go to READ.
  - After the handshake, if out_last=1: busy<=0, done<=1, go to IDLE.
- done is high for exactly one cycle, then low.
- start while busy (READ or SEND) is ignored and has no side effects.
- start in the IDLE cycle where done=1 is accepted. checksum clears at that edge.
- Register 0 is dumped like any other register; its value is whatever rd_data returns.
- Values are sampled live, one per READ cycle. Any GRF write that lands between two READ cycles is visible in later indices. Snapshot consistency is the integrator's job: stall writes while busy=1.
- ptr never exceeds NREG-1. There is no wrap-around inside a dump.
- Reset:
  - Values after reset: state=IDLE, ptr=0, busy=0, rd_addr=0, out_valid=0, out_idx=0, out_data=0, out_last=0, checksum=0, done=0.
  - Reset mid-dump aborts immediately. No done pulse follows, and no partial checksum is kept.
  - Reset has priority over start in the same cycle.

## Timing
- start sampled at edge E0 → busy=1 and READ during cycle 1.
- E1 → out_valid=1 for idx 0.
- With out_ready held high:
  - Handshake for idx k occurs at E(2k+2).
  - Throughput is one beat per 2 cycles.
  - Last handshake at E(2·NREG): E64 for NREG=32.
  - done=1, busy=0 during the cycle after E(2·NREG).
- Each cycle of out_ready=0 while out_valid=1 adds exactly one cycle to the total latency.
- rd_addr changes only on edges. The GRF path is rd_addr → rd_data → out_data register, so it is one combinational read per cycle.
- The checksum value including the final beat is visible in the same cycle that done=1.

## Test plan
- GRF R[i]=i, out_ready=1, pulse start → 32 beats, idx 0..31 with data=i, out_last only on idx 31; checksum=0x000001F0; done one cycle after E64; busy low from then on.
- Same setup, out_ready=0 for 5 cycles while idx 3 is valid → out_idx=3 and out_data=3 stable, rd_addr=3 constant; done arrives after E69; checksum unchanged at 0x1F0.
- R0=0, R[1..31]=0xFFFFFFFF → checksum=0xFFFFFFE1 (wraps mod 2^32); out_data for idx 0 is 0.
- start re-pulsed during idx 7 SEND → ignored; beat order, timing and checksum identical to the first test.
- reset asserted while idx 10 is in SEND → next cycle all outputs are at reset values and no done pulse appears. A new start dumps again from idx 0 with a fresh checksum.
- NREG=4, R[i]=0x10·i; start asserted in the cycle done=1 → second dump starts immediately with checksum cleared to 0. Both dumps end with checksum=0x60.

Source files
------------

// File: rtl/grf_dumper.sv
// ============================================================================
//  Module      : grf_dumper
//  Description : Walks the GRF read port from index 0 to NREG-1 and streams
//                each value out as an (index, data) beat, with a running
//                checksum and a one-cycle done pulse after the last beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_dumper #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [DW-1:0] checksum,
  output logic          done
);

  localparam logic [1:0]    c_ST_IDLE  = 2'd0;
  localparam logic [1:0]    c_ST_READ  = 2'd1;
  localparam logic [1:0]    c_ST_SEND  = 2'd2;
  localparam logic [AW-1:0] c_LAST_IDX = AW'(NREG - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic          r_out_valid;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          r_out_last;
  logic [DW-1:0] r_checksum;
  logic          r_done;
  logic          w_handshake;

  assign w_handshake = r_out_valid & out_ready;

  // The read port is parked at 0 whenever no dump is in progress.
  assign rd_addr   = (r_state == c_ST_IDLE) ? '0 : r_ptr;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign checksum  = r_checksum;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_checksum  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_ptr      <= '0;
            r_checksum <= '0;
            r_busy     <= 1'b1;
            r_state    <= c_ST_READ;
          end
        end
        c_ST_READ: begin
          r_out_data  <= rd_data;
          r_out_idx   <= r_ptr;
          r_out_last  <= (r_ptr == c_LAST_IDX);
          r_out_valid <= 1'b1;
          r_state     <= c_ST_SEND;
        end
        c_ST_SEND: begin
          // Beat fields hold until the sink accepts.
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_checksum  <= r_checksum + r_out_data;
            if (r_out_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= c_ST_IDLE;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= c_ST_READ;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
